// File: rtl/shift_pipe.sv
// rtl/shift_pipe.sv - two-stage pipelined 32-bit shifter with valid/ready handshake
// Optional feature: define SHIFT_ROT_EN to make op 11 a rotate-right; otherwise op 11 is SRL.

`timescale 1ns/1ps

// Thermometer decoder: y[k]=1 for every k below the shift amount.
module decode_dif (
  input  logic [4:0]  n_i,
  output logic [31:0] y_o
);
  genvar k;
  generate
    for (k = 0; k < 32; k++) begin : g_bit
      assign y_o[k] = (5'(k) < n_i);
    end
  endgenerate
endmodule

module shift_pipe #(
  parameter int TAG_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [1:0]       op_i,
  input  logic [31:0]      a_i,
  input  logic [4:0]       shamt_i,
  input  logic [TAG_W-1:0] tag_i,
  input  logic             flush_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [31:0]      result_o,
  output logic [TAG_W-1:0] tag_o
);

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;

  // stage 1 state
  logic             r_s1_valid;
  logic [1:0]       r_s1_op;
  logic [31:0]      r_s1_a;
  logic [4:0]       r_s1_shamt;
  logic [TAG_W-1:0] r_s1_tag;
  logic [31:0]      r_s1_mask;

  // stage 2 state
  logic             r_s2_valid;
  logic [31:0]      r_result;
  logic [TAG_W-1:0] r_tag;

  logic        w_s1_adv;
  logic        w_s2_adv;
  logic [31:0] w_mask;
  logic [31:0] w_fill;
  logic [31:0] w_shifted;

  // The mask is produced from the raw input so stage 2 only needs a bit reversal.
  decode_dif u_decode (
    .n_i (shamt_i),
    .y_o (w_mask)
  );

  // Handshake: a stage may load when it is empty or its contents move on this edge.
  always_comb begin
    w_s2_adv = ~r_s2_valid | ready_i;
    w_s1_adv = ~r_s1_valid | w_s2_adv;
  end

  assign ready_o  = w_s1_adv;
  assign valid_o  = r_s2_valid;
  assign result_o = r_result;
  assign tag_o    = r_tag;

  // Sign fill for SRA: reversing the low-n mask gives the top n bits set.
  always_comb begin
    w_fill = '0;
    for (int k = 0; k < 32; k++) begin
      w_fill[k] = r_s1_mask[31-k];
    end
  end

  // Stage 2 shift datapath.
  always_comb begin
    w_shifted = '0;
    case (r_s1_op)
      OP_SLL:  w_shifted = r_s1_a << r_s1_shamt;
      OP_SRL:  w_shifted = r_s1_a >> r_s1_shamt;
      OP_SRA:  w_shifted = (r_s1_a >> r_s1_shamt) | (r_s1_a[31] ? w_fill : 32'h0);
      default: begin
`ifdef SHIFT_ROT_EN
        if (r_s1_shamt == 5'd0) begin
          w_shifted = r_s1_a;
        end else begin
          w_shifted = (r_s1_a >> r_s1_shamt) | (r_s1_a << (6'd32 - {1'b0, r_s1_shamt}));
        end
`else
        w_shifted = r_s1_a >> r_s1_shamt;
`endif
      end
    endcase
  end

  // Stage 1 capture; flush kills the slot and drops any op offered alongside it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_s1_valid <= 1'b0;
      r_s1_op    <= '0;
      r_s1_a     <= '0;
      r_s1_shamt <= '0;
      r_s1_tag   <= '0;
      r_s1_mask  <= '0;
    end else if (flush_i) begin
      r_s1_valid <= 1'b0;
    end else if (w_s1_adv) begin
      r_s1_valid <= valid_i;
      if (valid_i) begin
        r_s1_op    <= op_i;
        r_s1_a     <= a_i;
        r_s1_shamt <= shamt_i;
        r_s1_tag   <= tag_i;
        r_s1_mask  <= w_mask;
      end
    end
  end

  // Stage 2 result register; data only changes when a real op arrives so outputs hold.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_s2_valid <= 1'b0;
      r_result   <= '0;
      r_tag      <= '0;
    end else if (flush_i) begin
      r_s2_valid <= 1'b0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_result <= w_shifted;
        r_tag    <= r_s1_tag;
      end
    end
  end

endmodule

// File: tb/tb_shift_pipe.sv
// tb/tb_shift_pipe.sv - directed bench for shift_pipe

`timescale 1ns/1ps

module tb_shift_pipe;

  localparam int TAG_W = 4;

  logic             clk = 1'b0;
  logic             rst_i = 1'b1;
  logic             valid_i = 1'b0;
  logic             ready_o;
  logic [1:0]       op_i = 2'b00;
  logic [31:0]      a_i = '0;
  logic [4:0]       shamt_i = '0;
  logic [TAG_W-1:0] tag_i = '0;
  logic             flush_i = 1'b0;
  logic             valid_o;
  logic             ready_i = 1'b1;
  logic [31:0]      result_o;
  logic [TAG_W-1:0] tag_o;

  int total = 0;
  int bad   = 0;

  shift_pipe #(.TAG_W(TAG_W)) dut (
    .clk_i    (clk),
    .rst_i    (rst_i),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .op_i     (op_i),
    .a_i      (a_i),
    .shamt_i  (shamt_i),
    .tag_i    (tag_i),
    .flush_i  (flush_i),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .result_o (result_o),
    .tag_o    (tag_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [4:0]  n;
    logic [31:0] exp;
  } vec_t;

  vec_t vt[13];

  // One op into an empty pipe: not visible after 1 edge, visible after 2.
  task automatic apply(input vec_t v, input int idx);
    @(negedge clk);
    ready_i = 1'b1;
    valid_i = 1'b1;
    op_i    = v.op;
    a_i     = v.a;
    shamt_i = v.n;
    tag_i   = TAG_W'(idx);
    #1;
    chk($sformatf("v%0d_ready", idx), 32'(ready_o), 32'd1);
    @(negedge clk);
    valid_i = 1'b0;
    #1;
    chk($sformatf("v%0d_early", idx), 32'(valid_o), 32'd0);
    @(negedge clk);
    #1;
    chk($sformatf("v%0d_valid", idx), 32'(valid_o), 32'd1);
    chk($sformatf("v%0d_result", idx), result_o, v.exp);
    chk($sformatf("v%0d_tag", idx), 32'(tag_o), 32'(idx));
  endtask

  initial begin
    int sent;
    int got;
    logic [31:0] bp_exp [4];

    vt[0]  = '{2'b10, 32'h8000_0000, 5'd4,  32'hF800_0000};
    vt[1]  = '{2'b01, 32'h8000_0000, 5'd31, 32'h0000_0001};
    vt[2]  = '{2'b00, 32'h0000_0001, 5'd0,  32'h0000_0001};
    vt[3]  = '{2'b10, 32'h7FFF_FFFF, 5'd31, 32'h0000_0000};
    vt[4]  = '{2'b10, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF};
    vt[5]  = '{2'b00, 32'h0000_00F1, 5'd4,  32'h0000_0F10};
    vt[6]  = '{2'b01, 32'hF000_000F, 5'd8,  32'h00F0_0000};
    vt[7]  = '{2'b10, 32'h8765_4321, 5'd0,  32'h8765_4321};
`ifdef SHIFT_ROT_EN
    vt[8]  = '{2'b11, 32'h0000_00F1, 5'd4,  32'h1000_000F};
    vt[12] = '{2'b11, 32'h8000_0001, 5'd1,  32'hC000_0000};
`else
    vt[8]  = '{2'b11, 32'h0000_00F1, 5'd4,  32'h0000_000F};
    vt[12] = '{2'b11, 32'h8000_0001, 5'd1,  32'h4000_0000};
`endif
    vt[9]  = '{2'b11, 32'h1234_5678, 5'd0,  32'h1234_5678};
    vt[10] = '{2'b10, 32'h9000_0000, 5'd1,  32'hC800_0000};
    vt[11] = '{2'b00, 32'hFFFF_FFFF, 5'd31, 32'h8000_0000};

    // reset state
    #2;
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_result", result_o, 32'd0);
    chk("rst_tag", 32'(tag_o), 32'd0);
    chk("rst_ready", 32'(ready_o), 32'd1);
    @(negedge clk);
    rst_i = 1'b0;

    for (int i = 0; i < 13; i++) begin
      apply(vt[i], i);
    end

    // back-to-back with 3 cycles of downstream stall once the first result shows
    for (int i = 0; i < 4; i++) bp_exp[i] = 32'(i + 1) << i;
    sent = 0;
    got  = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      ready_i = !(c >= 2 && c <= 4);
      valid_i = (sent < 4);
      op_i    = 2'b00;
      a_i     = 32'(sent + 1);
      shamt_i = 5'(sent);
      tag_i   = TAG_W'(sent);
      #1;
      if (c == 2) chk("bp_ready_low", 32'(ready_o), 32'd0);
      if (c >= 2 && c <= 4) begin
        chk($sformatf("bp_hold_valid_c%0d", c), 32'(valid_o), 32'd1);
        chk($sformatf("bp_hold_result_c%0d", c), result_o, 32'd1);
        chk($sformatf("bp_hold_tag_c%0d", c), 32'(tag_o), 32'd0);
      end
      if (valid_o && ready_i) begin
        if (got < 4) begin
          chk($sformatf("bp_tag_%0d", got), 32'(tag_o), 32'(got));
          chk($sformatf("bp_result_%0d", got), result_o, bp_exp[got]);
        end
        got++;
      end
      if (valid_i && ready_o) sent++;
    end
    valid_i = 1'b0;
    chk("bp_sent", 32'(sent), 32'd4);
    chk("bp_got", 32'(got), 32'd4);

    // flush with both stages full and a third op offered
    @(negedge clk);
    ready_i = 1'b1; valid_i = 1'b1; op_i = 2'b01; a_i = 32'h0000_0100; shamt_i = 5'd4; tag_i = 4'd5;
    @(negedge clk);
    a_i = 32'h0000_0200; tag_i = 4'd6;
    @(negedge clk);
    ready_i = 1'b0; flush_i = 1'b1; a_i = 32'h0000_0300; tag_i = 4'd7;
    #1;
    chk("fl_pre_valid", 32'(valid_o), 32'd1);
    @(negedge clk);
    flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
    #1;
    chk("fl_valid", 32'(valid_o), 32'd0);
    chk("fl_result_hold", result_o, 32'h0000_0010);
    chk("fl_tag_hold", 32'(tag_o), 32'd5);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1;
      chk($sformatf("fl_quiet_%0d", c), 32'(valid_o), 32'd0);
    end

    // flush on an empty pipe drops the op even though ready_o is high
    @(negedge clk);
    valid_i = 1'b1; flush_i = 1'b1; a_i = 32'h0000_0400; tag_i = 4'd8;
    #1;
    chk("fl2_ready", 32'(ready_o), 32'd1);
    @(negedge clk);
    valid_i = 1'b0; flush_i = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk($sformatf("fl2_quiet_%0d", c), 32'(valid_o), 32'd0);
      @(negedge clk);
    end
    apply(vt[0], 14);

    // asynchronous reset mid-stream
    @(negedge clk);
    ready_i = 1'b0; valid_i = 1'b1; op_i = 2'b00; a_i = 32'h3; shamt_i = 5'd1; tag_i = 4'd9;
    @(negedge clk);
    tag_i = 4'd10;
    @(negedge clk);
    valid_i = 1'b0;
    #1;
    chk("ar_pre_valid", 32'(valid_o), 32'd1);
    #2;
    rst_i = 1'b1;
    #1;
    chk("ar_valid", 32'(valid_o), 32'd0);
    chk("ar_result", result_o, 32'd0);
    chk("ar_tag", 32'(tag_o), 32'd0);
    chk("ar_ready", 32'(ready_o), 32'd1);
    @(negedge clk);
    ready_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1;
      chk($sformatf("ar_quiet_%0d", c), 32'(valid_o), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
